// File: rtl/gc_flush_sequencer.sv
// Global-control sequencer: orders fence.i, returns, traps, interrupts and WFI,
// draining or discarding in-flight work before redirecting fetch.
//
// state      | meaning
// -----------+------------------------------------------------------------
// RESET      | first cycle after reset, loads the clear timer
// INIT_CLEAR | post-reset clear of pipeline state, CLEAR_DEPTH cycles
// IDLE       | normal issue, watching requests, exceptions and interrupts
// DRAIN      | waiting for in-flight work (ifence/ret) or the exception to retire
// WFI_WAIT   | core asleep until interrupt, exception or timeout
// SETTLE     | interrupt must stay pending SETTLE_CYCLES cycles
// INT_DRAIN  | interrupt accepted, waiting for pipeline to empty
// FLUSH      | one-cycle redirect with pc_override
// DISCARD    | squashing leftovers until issue count and stores are empty
module gc_flush_sequencer #(
  parameter int NUM_SOURCES   = 4,
  parameter int ID_W          = 3,
  parameter int SETTLE_CYCLES = 2,
  parameter int WFI_TIMEOUT   = 0,
  parameter int CLEAR_DEPTH   = 64,
  localparam int SEL_W        = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  input  logic [1:0]                  req_type,
  input  logic [31:0]                 req_pc_p4,
  input  logic [NUM_SOURCES-1:0]      exc_valid,
  input  logic [NUM_SOURCES*ID_W-1:0] exc_id,
  input  logic [SEL_W-1:0]            exc_src_sel,
  input  logic [ID_W-1:0]             oldest_id,
  input  logic                        interrupt_pending,
  input  logic [ID_W:0]               post_issue_count,
  input  logic                        sq_empty,
  input  logic                        stores_pending,
  input  logic [31:0]                 trap_target_pc,
  input  logic [31:0]                 epc,
  output logic [NUM_SOURCES-1:0]      exc_ack,
  output logic                        fetch_hold,
  output logic                        issue_hold,
  output logic                        retire_hold,
  output logic                        writeback_suppress,
  output logic                        init_clear,
  output logic                        sq_flush,
  output logic                        pc_override,
  output logic [31:0]                 pc,
  output logic                        exception_taken,
  output logic                        interrupt_taken,
  output logic                        mret,
  output logic                        sret,
  output logic                        wfi_active
);

  localparam logic [1:0] REQ_IFENCE = 2'd0;
  localparam logic [1:0] REQ_MRET   = 2'd1;
  localparam logic [1:0] REQ_SRET   = 2'd2;
  localparam logic [1:0] REQ_WFI    = 2'd3;

  localparam int CLR_W = (CLEAR_DEPTH > 1) ? $clog2(CLEAR_DEPTH) : 1;
  localparam int ST_W  = $clog2(SETTLE_CYCLES + 1);
  localparam int WT_W  = (WFI_TIMEOUT > 1) ? $clog2(WFI_TIMEOUT) : 1;

  localparam logic [CLR_W-1:0] CLR_LOAD  = CLR_W'(CLEAR_DEPTH - 1);
  localparam logic [ST_W-1:0]  ST_TC     = ST_W'(SETTLE_CYCLES);
  localparam logic [WT_W-1:0]  WT_LOAD   = (WFI_TIMEOUT > 0) ? WT_W'(WFI_TIMEOUT - 1) : '0;
  localparam bit               WFI_TO_EN = (WFI_TIMEOUT > 0);

  typedef enum logic [3:0] {
    S_RESET,
    S_INIT_CLEAR,
    S_IDLE,
    S_DRAIN,
    S_WFI_WAIT,
    S_SETTLE,
    S_INT_DRAIN,
    S_FLUSH,
    S_DISCARD
  } state_t;

  state_t state, next_state;

  logic [CLR_W-1:0] clr_cnt;
  logic [ST_W-1:0]  settle_cnt;
  logic [ST_W-1:0]  settle_nxt;
  logic [WT_W-1:0]  wfi_cnt;

  logic        ifence_q, mret_q, sret_q;
  logic [31:0] pc_p4_q;

  logic            sel_valid;
  logic [ID_W-1:0] sel_id;
  logic            exc_hit, exc_any, post_idle, ret_q, flush_entry, take_exc, take_int;
  logic [31:0]     redirect_pc;

  always_comb begin
    sel_valid = 1'b0;
    sel_id    = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (exc_src_sel == SEL_W'(i)) begin
        sel_valid = exc_valid[i];
        sel_id    = exc_id[i*ID_W +: ID_W];
      end
    end
  end

  assign exc_hit    = sel_valid && (sel_id == oldest_id);
  assign exc_any    = |exc_valid;
  assign post_idle  = (post_issue_count == '0) && sq_empty;
  assign ret_q      = mret_q || sret_q;
  assign settle_nxt = settle_cnt + ST_W'(1);

  always_comb begin
    next_state = state;
    case (state)
      S_RESET:      next_state = S_INIT_CLEAR;
      S_INIT_CLEAR: if (clr_cnt == '0) next_state = S_IDLE;
      S_IDLE: begin
        if (exc_hit)                                              next_state = S_FLUSH;
        else if ((req_valid && req_type != REQ_WFI) || exc_any)   next_state = S_DRAIN;
        else if (req_valid)                                       next_state = S_WFI_WAIT;
        else if (interrupt_pending)                               next_state = S_SETTLE;
      end
      S_DRAIN:
        if (exc_hit || ((ifence_q || ret_q) && post_idle)) next_state = S_FLUSH;
      S_WFI_WAIT: begin
        if (exc_hit)                            next_state = S_FLUSH;
        else if (interrupt_pending)             next_state = S_SETTLE;
        else if (WFI_TO_EN && wfi_cnt == '0)    next_state = S_IDLE;
      end
      S_SETTLE: begin
        if (!interrupt_pending)       next_state = S_IDLE;
        else if (settle_nxt == ST_TC) next_state = S_INT_DRAIN;
      end
      S_INT_DRAIN: if (post_idle || exc_hit) next_state = S_FLUSH;
      S_FLUSH:     next_state = S_DISCARD;
      S_DISCARD:
        if (post_issue_count == '0 && !stores_pending) next_state = S_IDLE;
      default:     next_state = S_RESET;
    endcase
  end

  // Cause priority on FLUSH entry: exception, then ret/ifence, then interrupt.
  assign flush_entry = (next_state == S_FLUSH) && (state != S_FLUSH);
  assign take_exc    = flush_entry && exc_hit;
  assign take_int    = flush_entry && !exc_hit && !ifence_q && !ret_q && (state == S_INT_DRAIN);

  assign exception_taken = take_exc;
  assign interrupt_taken = take_int;
  assign mret            = flush_entry && !exc_hit && mret_q;
  assign sret            = flush_entry && !exc_hit && sret_q;

  always_comb begin
    exc_ack = '0;
    for (int i = 0; i < NUM_SOURCES; i++)
      exc_ack[i] = take_exc && (exc_src_sel == SEL_W'(i));
  end

  always_comb begin
    redirect_pc = trap_target_pc;
    if (!exc_hit) begin
      if (ifence_q)   redirect_pc = pc_p4_q;
      else if (ret_q) redirect_pc = epc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= S_RESET;
      fetch_hold         <= 1'b1;
      issue_hold         <= 1'b1;
      writeback_suppress <= 1'b1;
      retire_hold        <= 1'b0;
      init_clear         <= 1'b0;
      pc_override        <= 1'b0;
      sq_flush           <= 1'b0;
      wfi_active         <= 1'b0;
      pc                 <= '0;
      clr_cnt            <= '0;
      settle_cnt         <= '0;
      wfi_cnt            <= '0;
      ifence_q           <= 1'b0;
      mret_q             <= 1'b0;
      sret_q             <= 1'b0;
      pc_p4_q            <= '0;
    end else begin
      state              <= next_state;
      fetch_hold         <= next_state inside {S_INIT_CLEAR, S_DRAIN, S_FLUSH, S_INT_DRAIN, S_WFI_WAIT};
      issue_hold         <= (next_state != S_IDLE);
      writeback_suppress <= next_state inside {S_INIT_CLEAR, S_DISCARD};
      retire_hold        <= (next_state == S_FLUSH);
      init_clear         <= (next_state == S_INIT_CLEAR);
      pc_override        <= next_state inside {S_FLUSH, S_INIT_CLEAR};
      sq_flush           <= (state == S_DISCARD) && (next_state == S_IDLE);
      wfi_active         <= (next_state == S_WFI_WAIT);

      if (flush_entry) pc <= redirect_pc;

      if (state == S_RESET)                           clr_cnt <= CLR_LOAD;
      else if (state == S_INIT_CLEAR && clr_cnt != '0) clr_cnt <= clr_cnt - CLR_W'(1);

      if (state == S_SETTLE && next_state == S_SETTLE) settle_cnt <= settle_nxt;
      else                                             settle_cnt <= '0;

      if (state == S_IDLE && next_state == S_WFI_WAIT)  wfi_cnt <= WT_LOAD;
      else if (state == S_WFI_WAIT && wfi_cnt != '0)    wfi_cnt <= wfi_cnt - WT_W'(1);

      // Flag clearing on flush wins over a request seen in the same cycle.
      if (flush_entry) begin
        ifence_q <= 1'b0;
        mret_q   <= 1'b0;
        sret_q   <= 1'b0;
      end else if (state == S_IDLE && req_valid) begin
        ifence_q <= (req_type == REQ_IFENCE);
        mret_q   <= (req_type == REQ_MRET);
        sret_q   <= (req_type == REQ_SRET);
        pc_p4_q  <= req_pc_p4;
      end
    end
  end

endmodule
